// File: rtl/vga_timing_pkg.sv
// Shared timing defaults and types for the 640x480@60 scan generator and its
// sprite-position shadow register.
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FP      = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BP      = 48;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FP      = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 33;

  localparam int unsigned H_TOTAL     = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL     = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned COMMIT_LINE = V_VISIBLE;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } pos_state_t;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_pos_shadow.sv
// Per-frame shadow of the sprite position: writes collect in a pending slot and
// move to obj_x/obj_y only on the commit strobe, so drawers see a frame-stable value.
module vga_pos_shadow
  import vga_timing_pkg::*;
(
  input  logic   vga_clk,
  input  logic   reset_n,
  input  logic   pos_wr,
  input  coord_t pos_x,
  input  coord_t pos_y,
  input  logic   commit,
  output coord_t obj_x,
  output coord_t obj_y,
  output logic   pos_ack
);

  pos_state_t state_q, state_d;
  coord_t     pend_x_q, pend_x_d;
  coord_t     pend_y_q, pend_y_d;
  coord_t     obj_x_q, obj_x_d;
  coord_t     obj_y_q, obj_y_d;
  logic       ack_q, ack_d;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      pend_x_q <= '0;
      pend_y_q <= '0;
      obj_x_q  <= '0;
      obj_y_q  <= '0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_x_q <= pend_x_d;
      pend_y_q <= pend_y_d;
      obj_x_q  <= obj_x_d;
      obj_y_q  <= obj_y_d;
      ack_q    <= ack_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_x_d = pend_x_q;
    pend_y_d = pend_y_q;
    obj_x_d  = obj_x_q;
    obj_y_d  = obj_y_q;
    ack_d    = 1'b0;
    if (commit && state_q == PENDING) begin
      obj_x_d = pend_x_q;
      obj_y_d = pend_y_q;
      ack_d   = 1'b1;
      state_d = IDLE;
    end
    // A write on the commit cycle is held over: the commit above used the old slot.
    if (pos_wr) begin
      pend_x_d = pos_x;
      pend_y_d = pos_y;
      state_d  = PENDING;
    end
  end

  assign obj_x   = obj_x_q;
  assign obj_y   = obj_y_q;
  assign pos_ack = ack_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-scan producer: free-running h/v counters, registered position/sync/blank
// decode (one cycle behind the counters) and the frame-synchronous position shadow.
module vga_timing_gen
  import vga_timing_pkg::coord_t;
#(
  parameter int unsigned H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int unsigned H_FP      = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP      = vga_timing_pkg::H_BP,
  parameter int unsigned V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int unsigned V_FP      = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP      = vga_timing_pkg::V_BP
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       pos_wr,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic [9:0] obj_x,
  output logic [9:0] obj_y,
  output logic       pos_ack,
  output logic [7:0] frame_cnt
);

  localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
  localparam coord_t H_SYNC_S = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t H_SYNC_E = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t H_LAST   = coord_t'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
  localparam coord_t V_SYNC_S = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t V_SYNC_E = coord_t'(V_VISIBLE + V_FP + V_SYNC);
  localparam coord_t V_LAST   = coord_t'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);

  coord_t     hc_q, hc_d, vc_q, vc_d;
  coord_t     draw_x_q, draw_y_q;
  logic       blank_q, blank_d;
  logic       hs_q, hs_d, vs_q, vs_d;
  logic       fs_q, fs_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       commit;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q        <= '0;
      vc_q        <= '0;
      draw_x_q    <= '0;
      draw_y_q    <= '0;
      blank_q     <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      fs_q        <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      draw_x_q    <= hc_q;
      draw_y_q    <= vc_q;
      blank_q     <= blank_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      fs_q        <= fs_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    hc_d = hc_q + 10'd1;
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
    end
    blank_d     = (hc_q < H_VIS) && (vc_q < V_VIS);
    hs_d        = !((hc_q >= H_SYNC_S) && (hc_q < H_SYNC_E));
    vs_d        = !((vc_q >= V_SYNC_S) && (vc_q < V_SYNC_E));
    fs_d        = (hc_q == '0) && (vc_q == '0);
    frame_cnt_d = frame_cnt_q + {7'd0, fs_d};
    // First pixel of vertical blank: drawers are idle, so the position may move.
    commit      = (hc_q == '0) && (vc_q == V_VIS);
  end

  vga_pos_shadow u_pos_shadow (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .pos_wr  (pos_wr),
    .pos_x   (pos_x),
    .pos_y   (pos_y),
    .commit  (commit),
    .obj_x   (obj_x),
    .obj_y   (obj_y),
    .pos_ack (pos_ack)
  );

  assign DrawX       = draw_x_q;
  assign DrawY       = draw_y_q;
  assign blank       = blank_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign frame_start = fs_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a shrunken raster (25x19) so that
// several whole frames fit in a short run.
module tb_vga_timing_gen;

  localparam int HV = 16, HF = 2, HS = 4, HB = 3;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int COMMIT_POS = VV * HT;

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       pos_wr = 1'b0;
  logic [9:0] pos_x = '0, pos_y = '0;
  logic [9:0] DrawX, DrawY, obj_x, obj_y;
  logic       blank, hs, vs, frame_start, pos_ack;
  logic [7:0] frame_cnt;

  int total = 0;
  int bad = 0;

  // Reference model: k = edges since reset release; scan position of edge k is (k-1) mod FRAME.
  int         k = 0;
  logic       m_pend = 1'b0;
  logic [9:0] m_pend_x = '0, m_pend_y = '0;
  logic [9:0] m_obj_x = '0, m_obj_y = '0;
  logic       m_ack = 1'b0;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .pos_wr(pos_wr), .pos_x(pos_x), .pos_y(pos_y),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank), .hs(hs), .vs(vs),
    .frame_start(frame_start), .obj_x(obj_x), .obj_y(obj_y), .pos_ack(pos_ack),
    .frame_cnt(frame_cnt)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic int ex_x();
    return ((k - 1) % FRAME) % HT;
  endfunction

  function automatic int ex_y();
    return ((k - 1) % FRAME) / HT;
  endfunction

  task automatic tick(input logic wr, input logic [9:0] x, input logic [9:0] y);
    pos_wr = wr;
    pos_x  = x;
    pos_y  = y;
    @(posedge vga_clk);
    k++;
    m_ack = 1'b0;
    if (((k - 1) % FRAME) == COMMIT_POS && m_pend) begin
      m_obj_x = m_pend_x;
      m_obj_y = m_pend_y;
      m_ack   = 1'b1;
      m_pend  = 1'b0;
    end
    if (wr) begin
      m_pend   = 1'b1;
      m_pend_x = x;
      m_pend_y = y;
    end
    #1;
    pos_wr = 1'b0;
  endtask

  task automatic do_reset();
    pos_wr  = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge vga_clk);
    #1;
    reset_n = 1'b1;
    k = 0;
    m_pend = 1'b0;
    m_obj_x = '0;
    m_obj_y = '0;
    m_ack = 1'b0;
  endtask

  // Ticks until the next edge will sample scan position 'target'.
  task automatic advance_until_next(input int target);
    for (int i = 0; i <= FRAME && (k % FRAME) != target; i++) tick(1'b0, '0, '0);
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #3;
    total++; if (DrawX !== 10'd0) begin bad++; $display("FAIL rst_drawx actual=%0d required=0", DrawX); end
    total++; if (DrawY !== 10'd0) begin bad++; $display("FAIL rst_drawy actual=%0d required=0", DrawY); end
    total++; if ({blank, hs, vs, frame_start, pos_ack} !== 5'b01100) begin bad++; $display("FAIL rst_flags actual=%b required=01100", {blank, hs, vs, frame_start, pos_ack}); end
    total++; if ({obj_x, obj_y} !== 20'd0) begin bad++; $display("FAIL rst_obj actual=%0d,%0d required=0,0", obj_x, obj_y); end
    total++; if (frame_cnt !== 8'd0) begin bad++; $display("FAIL rst_fcnt actual=%0d required=0", frame_cnt); end
    @(posedge vga_clk);
    #1 reset_n = 1'b1;
    k = 0;
    tick(1'b0, '0, '0);
    total++; if ({DrawX, DrawY} !== 20'd0) begin bad++; $display("FAIL first_pos actual=%0d,%0d required=0,0", DrawX, DrawY); end
    total++; if ({blank, hs, vs, frame_start} !== 4'b1111) begin bad++; $display("FAIL first_flags actual=%b required=1111", {blank, hs, vs, frame_start}); end
    total++; if (frame_cnt !== 8'd1) begin bad++; $display("FAIL first_fcnt actual=%0d required=1", frame_cnt); end
  endtask

  task automatic test_line();
    int fall_x = -1, hs_first = -1, hs_low = 0;
    do_reset();
    tick(1'b0, '0, '0);
    for (int i = 0; i < HT; i++) begin
      tick(1'b0, '0, '0);
      if (DrawY == 10'd0 && !blank && fall_x < 0) fall_x = int'(DrawX);
      if (DrawY == 10'd0 && !hs) begin
        if (hs_first < 0) hs_first = int'(DrawX);
        hs_low++;
      end
    end
    total++; if (fall_x != HV) begin bad++; $display("FAIL blank_fall actual=%0d required=%0d", fall_x, HV); end
    total++; if (hs_first != HV + HF) begin bad++; $display("FAIL hs_start actual=%0d required=%0d", hs_first, HV + HF); end
    total++; if (hs_low != HS) begin bad++; $display("FAIL hs_width actual=%0d required=%0d", hs_low, HS); end
    total++; if ({DrawX, DrawY} !== {10'd0, 10'd1}) begin bad++; $display("FAIL line_wrap actual=%0d,%0d required=0,1", DrawX, DrawY); end
  endtask

  task automatic test_frame();
    int period = 0, vs_low = 0, vs_first = -1;
    do_reset();
    tick(1'b0, '0, '0);
    for (int i = 0; i < FRAME + 5; i++) begin
      tick(1'b0, '0, '0);
      period++;
      if (frame_start) break;
      if (!vs) begin
        vs_low++;
        if (vs_first < 0) vs_first = int'(DrawY);
      end
    end
    total++; if (period != FRAME) begin bad++; $display("FAIL fs_period actual=%0d required=%0d", period, FRAME); end
    total++; if (frame_cnt !== 8'd2) begin bad++; $display("FAIL fcnt_2 actual=%0d required=2", frame_cnt); end
    total++; if (vs_first != VV + VF) begin bad++; $display("FAIL vs_start actual=%0d required=%0d", vs_first, VV + VF); end
    total++; if (vs_low != VS * HT) begin bad++; $display("FAIL vs_width actual=%0d required=%0d", vs_low, VS * HT); end
  endtask

  task automatic test_commit();
    int pre_acks = 0, early = 0, post_acks = 0;
    do_reset();
    tick(1'b0, '0, '0);
    advance_until_next(5 * HT);
    tick(1'b1, 10'd100, 10'd200);
    for (int i = 0; i <= FRAME && (k % FRAME) != COMMIT_POS; i++) begin
      tick(1'b0, '0, '0);
      if (pos_ack) pre_acks++;
      if (obj_x !== 10'd0 || obj_y !== 10'd0) early++;
    end
    tick(1'b0, '0, '0);
    total++; if (early != 0 || pre_acks != 0) begin bad++; $display("FAIL obj_early actual=%0d/%0d required=0/0", early, pre_acks); end
    total++; if ({DrawX, DrawY} !== {10'd0, 10'(VV)}) begin bad++; $display("FAIL commit_pos actual=%0d,%0d required=0,%0d", DrawX, DrawY, VV); end
    total++; if ({obj_x, obj_y} !== {10'd100, 10'd200}) begin bad++; $display("FAIL commit_obj actual=%0d,%0d required=100,200", obj_x, obj_y); end
    total++; if (pos_ack !== 1'b1) begin bad++; $display("FAIL commit_ack actual=%b required=1", pos_ack); end
    for (int i = 0; i < 2 * HT; i++) begin
      tick(1'b0, '0, '0);
      if (pos_ack) post_acks++;
    end
    total++; if (post_acks != 0) begin bad++; $display("FAIL ack_once actual=%0d required=0 extra", post_acks); end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    do_reset();
    tick(1'b0, '0, '0);
    advance_until_next(2 * HT + 3);
    tick(1'b1, 10'd5, 10'd5);
    repeat (7) tick(1'b0, '0, '0);
    tick(1'b1, 10'd7, 10'd9);
    advance_until_next(COMMIT_POS);
    tick(1'b1, 10'd3, 10'd3);
    total++; if ({obj_x, obj_y} !== {10'd7, 10'd9}) begin bad++; $display("FAIL last_wins actual=%0d,%0d required=7,9", obj_x, obj_y); end
    total++; if (pos_ack !== 1'b1) begin bad++; $display("FAIL b2b_ack actual=%b required=1", pos_ack); end
    for (int i = 0; i < FRAME - 1; i++) begin
      tick(1'b0, '0, '0);
      if (pos_ack) acks++;
    end
    total++; if ({obj_x, obj_y} !== {10'd7, 10'd9} || acks != 0) begin bad++; $display("FAIL held_frame actual=%0d,%0d acks=%0d required=7,9 acks=0", obj_x, obj_y, acks); end
    tick(1'b0, '0, '0);
    total++; if ({obj_x, obj_y, pos_ack} !== {10'd3, 10'd3, 1'b1}) begin bad++; $display("FAIL deferred actual=%0d,%0d ack=%b required=3,3 ack=1", obj_x, obj_y, pos_ack); end
  endtask

  task automatic test_reset_midframe();
    int acks = 0, moved = 0;
    do_reset();
    tick(1'b0, '0, '0);
    advance_until_next(3 * HT);
    tick(1'b1, 10'd50, 10'd60);
    advance_until_next(6 * HT + 10);
    tick(1'b0, '0, '0);
    total++; if ({DrawX, DrawY} !== {10'd10, 10'd6}) begin bad++; $display("FAIL pre_rst_pos actual=%0d,%0d required=10,6", DrawX, DrawY); end
    reset_n = 1'b0;
    #1;
    total++; if ({DrawX, DrawY, obj_x, obj_y} !== 40'd0) begin bad++; $display("FAIL midrst_vals actual=%0d,%0d,%0d,%0d required=0,0,0,0", DrawX, DrawY, obj_x, obj_y); end
    total++; if ({blank, hs, vs, frame_start, pos_ack, frame_cnt} !== {5'b01100, 8'd0}) begin bad++; $display("FAIL midrst_flags actual=%b/%0d required=01100/0", {blank, hs, vs, frame_start, pos_ack}, frame_cnt); end
    do_reset();
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick(1'b0, '0, '0);
      if (pos_ack) acks++;
      if (obj_x !== 10'd0 || obj_y !== 10'd0) moved++;
    end
    total++; if (acks != 0 || moved != 0) begin bad++; $display("FAIL pend_discard actual=acks %0d moved %0d required=0 0", acks, moved); end
  endtask

  task automatic test_random_scan();
    logic       wr;
    logic [9:0] x, y;
    do_reset();
    for (int i = 0; i < 3 * FRAME; i++) begin
      wr = ($urandom_range(0, 39) == 0);
      if ((k % FRAME) == COMMIT_POS) wr = 1'($urandom_range(0, 1));
      x = 10'($urandom_range(0, 1023));
      y = 10'($urandom_range(0, 1023));
      if (wr) $display("write x=%0d y=%0d edge=%0d", x, y, k + 1);
      tick(wr, x, y);
      total++; if (DrawX !== 10'(ex_x()) || DrawY !== 10'(ex_y())) begin bad++; $display("FAIL rnd_pos edge=%0d actual=%0d,%0d required=%0d,%0d", k, DrawX, DrawY, ex_x(), ex_y()); end
      total++; if (blank !== (ex_x() < HV && ex_y() < VV)) begin bad++; $display("FAIL rnd_blank edge=%0d actual=%b", k, blank); end
      total++; if (hs !== !(ex_x() >= HV + HF && ex_x() < HV + HF + HS)) begin bad++; $display("FAIL rnd_hs edge=%0d actual=%b", k, hs); end
      total++; if (vs !== !(ex_y() >= VV + VF && ex_y() < VV + VF + VS)) begin bad++; $display("FAIL rnd_vs edge=%0d actual=%b", k, vs); end
      total++; if (frame_start !== (ex_x() == 0 && ex_y() == 0)) begin bad++; $display("FAIL rnd_fs edge=%0d actual=%b", k, frame_start); end
      total++; if (frame_cnt !== 8'(((k - 1) / FRAME + 1) % 256)) begin bad++; $display("FAIL rnd_fcnt edge=%0d actual=%0d required=%0d", k, frame_cnt, ((k - 1) / FRAME + 1) % 256); end
      total++; if ({obj_x, obj_y, pos_ack} !== {m_obj_x, m_obj_y, m_ack}) begin bad++; $display("FAIL rnd_obj edge=%0d actual=%0d,%0d,%b required=%0d,%0d,%b", k, obj_x, obj_y, pos_ack, m_obj_x, m_obj_y, m_ack); end
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_commit();
    test_back_to_back();
    test_reset_midframe();
    test_random_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
